// File: rtl/rede_in_fifo.sv
// rtl/rede_in_fifo.sv - per-channel input FIFOs feeding the processor io_in bus through a one-hot read strobe
module rede_in_fifo #(
    parameter int NUBITS = 31,
    parameter int NUIOIN = 4,
    parameter int DEPTH  = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUIOIN*NUBITS-1:0]                in_data,
    input  logic [NUIOIN-1:0]                       in_valid,
    output logic [NUIOIN-1:0]                       in_ready,
    input  logic [NUIOIN-1:0]                       req_in,
    output logic signed [NUBITS-1:0]                io_in,
    output logic [NUIOIN-1:0]                       underflow,
    output logic                                    req_err,
    input  logic                                    clr_err,
    output logic [NUIOIN*($clog2(DEPTH)+1)-1:0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [NUBITS-1:0] mem   [NUIOIN][DEPTH];
    logic [AW-1:0]     wptr  [NUIOIN];
    logic [AW-1:0]     rptr  [NUIOIN];
    logic [CW-1:0]     count [NUIOIN];
    logic [NUBITS-1:0] hold  [NUIOIN];

    logic              one_hot;
    logic              multi_hot;
    logic [NUIOIN-1:0] push;
    logic [NUIOIN-1:0] pop;
    logic [NUIOIN-1:0] empty_hit;

    // Classify the strobe: exactly one bit set selects a channel, more than one is an error
    always_comb begin
        one_hot   = (req_in != '0) && ((req_in & (req_in - NUIOIN'(1))) == '0);
        multi_hot = (req_in != '0) && !one_hot;
    end

    for (genvar k = 0; k < NUIOIN; k++) begin : g_chan
        assign in_ready[k]          = (count[k] != CW'(DEPTH));
        assign push[k]              = in_valid[k] && in_ready[k];
        // An empty channel never pops, even when a push lands in the same cycle
        assign pop[k]               = one_hot && req_in[k] && (count[k] != '0);
        assign empty_hit[k]         = one_hot && req_in[k] && (count[k] == '0);
        assign level[k*CW +: CW]    = count[k];
    end

    // Zero-latency read mux: head sample if present, otherwise the last popped sample
    always_comb begin
        io_in = '0;
        for (int k = 0; k < NUIOIN; k++) begin
            if (one_hot && req_in[k]) begin
                io_in = (count[k] != '0) ? mem[k][rptr[k]] : hold[k];
            end
        end
    end

    // Sample storage is written only on an accepted push; contents need no reset
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUIOIN; k++) begin
            if (push[k]) begin
                mem[k][wptr[k]] <= in_data[k*NUBITS +: NUBITS];
            end
        end
    end

    // Pointers, occupancy and hold registers per channel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUIOIN; k++) begin
                wptr[k]  <= '0;
                rptr[k]  <= '0;
                count[k] <= '0;
                hold[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NUIOIN; k++) begin
                if (push[k]) begin
                    wptr[k] <= wptr[k] + AW'(1);
                end
                if (pop[k]) begin
                    rptr[k] <= rptr[k] + AW'(1);
                    hold[k] <= mem[k][rptr[k]];
                end
                if (push[k] && !pop[k]) begin
                    count[k] <= count[k] + CW'(1);
                end else if (pop[k] && !push[k]) begin
                    count[k] <= count[k] - CW'(1);
                end
            end
        end
    end

    // Sticky error flags; a new event in the same cycle as clr_err keeps the flag set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underflow <= '0;
            req_err   <= 1'b0;
        end else begin
            underflow <= (clr_err ? '0 : underflow) | empty_hit;
            req_err   <= (clr_err ? 1'b0 : req_err) | multi_hot;
        end
    end

endmodule
